// File: rtl/lcd_pkg.sv
// Shared types, init command ROM and command classification for the LCD bus scheduler.
// Pure declarations: no latency, no flow control of its own.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT_LOAD,
    ST_SETUP,
    ST_E_HIGH,
    ST_HOLD,
    ST_WAIT,
    ST_IDLE
  } lcd_state_e;

  // One bus transfer as it appears on the RS/DB pins.
  typedef struct packed {
    logic       rs;
    logic [7:0] dat;
  } lcd_xfer_t;

  localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;

  // Clear and return-home need the long execution wait on the controller.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
  endfunction

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_CMD_FUNCSET;
      2'd1:    return LCD_CMD_DISPON;
      2'd2:    return LCD_CMD_CLEAR;
      default: return LCD_CMD_ENTRY;
    endcase
  endfunction

  function automatic int cyc_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter shared by every timed scheduler state; done is high while the count is zero.
// Load takes effect on the next edge; no backpressure.
module lcd_cycle_timer #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_scheduler.sv
// HD44780 bus scheduler: power-up init, then arbitrated requester writes; ack one cycle after valid seen in IDLE.
// Requesters hold valid until ack; LCD_SCHED_RR_EN selects round-robin, otherwise port 0 has fixed priority.
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC        = 2,
  parameter int E_HIGH_CYC       = 12,
  parameter int HOLD_CYC         = 1,
  parameter int CMD_WAIT_CYC     = 2000,
  parameter int CLEAR_WAIT_CYC   = 80000,
  parameter int POWERUP_WAIT_CYC = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ack,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ack,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [7:0] lcd_db,
  output logic       init_done,
  output logic       busy
);

  localparam int MAX_CYC = cyc_max(cyc_max(cyc_max(SETUP_CYC, E_HIGH_CYC), cyc_max(HOLD_CYC, CMD_WAIT_CYC)),
                                   cyc_max(CLEAR_WAIT_CYC, POWERUP_WAIT_CYC));
  localparam int CW = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EHIGH_LD = CW'(E_HIGH_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] CMD_LD   = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLR_LD   = CW'(CLEAR_WAIT_CYC - 1);
  localparam logic [CW-1:0] PWRUP_LD = CW'(POWERUP_WAIT_CYC - 1);

  lcd_state_e    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic          init_done_q, init_done_d;
  lcd_xfer_t     bus_q, bus_d;
  logic          lcd_e_q, lcd_e_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_done;
  logic          pick1;

  // Reset value preloads the power-up wait so PWRUP needs no extra load cycle.
  lcd_cycle_timer #(
    .W      (CW),
    .RST_VAL(PWRUP_LD)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (tmr_load),
    .value(tmr_val),
    .done (tmr_done)
  );

`ifdef LCD_SCHED_RR_EN
  // ptr_q names the port that wins the next tie.
  logic ptr_q, ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign pick1 = req1_valid && (!req0_valid || ptr_q);
`else
  assign pick1 = !req0_valid;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    bus_d       = bus_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = SETUP_LD;
`ifdef LCD_SCHED_RR_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      ST_PWRUP: begin
        if (tmr_done) state_d = ST_INIT_LOAD;
      end
      ST_INIT_LOAD: begin
        bus_d    = '{rs: 1'b0, dat: init_rom(idx_q)};
        tmr_load = 1'b1;
        tmr_val  = SETUP_LD;
        state_d  = ST_SETUP;
      end
      ST_SETUP: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = EHIGH_LD;
          state_d  = ST_E_HIGH;
        end
      end
      ST_E_HIGH: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = is_long_cmd(bus_q.rs, bus_q.dat) ? CLR_LD : CMD_LD;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tmr_done) begin
          if (init_done_q) begin
            state_d = ST_IDLE;
          end else if (idx_q == 2'd3) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_INIT_LOAD;
          end
        end
      end
      ST_IDLE: begin
        if (init_done_q && (req0_valid || req1_valid)) begin
          ack0_d   = !pick1;
          ack1_d   = pick1;
          bus_d    = pick1 ? '{rs: req1_rs, dat: req1_data} : '{rs: req0_rs, dat: req0_data};
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
          state_d  = ST_SETUP;
`ifdef LCD_SCHED_RR_EN
          ptr_d    = !pick1;
`endif
        end
      end
      default: state_d = ST_PWRUP;
    endcase
    lcd_e_d = (state_d == ST_E_HIGH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PWRUP;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      bus_q       <= '0;
      lcd_e_q     <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      bus_q       <= bus_d;
      lcd_e_q     <= lcd_e_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
    end
  end

  assign req0_ack  = ack0_q;
  assign req1_ack  = ack1_q;
  assign lcd_rs    = bus_q.rs;
  assign lcd_db    = bus_q.dat;
  assign lcd_e     = lcd_e_q;
  assign init_done = init_done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Randomized bench for lcd_bus_scheduler: a transaction-level model predicts ack cycles, grants,
// E pulse timing and bus contents from the timing parameters, and every observation is compared to it.
module tb_lcd_bus_scheduler;

  localparam int S   = 2;
  localparam int EH  = 4;
  localparam int H   = 1;
  localparam int CMD = 20;
  localparam int CLR = 200;
  localparam int P   = 100;
  localparam int BUDGET = 5000;

`ifdef LCD_SCHED_RR_EN
  localparam logic [3:0] EXP_GRANTS = 4'b1010;
`else
  localparam logic [3:0] EXP_GRANTS = 4'b0000;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid = 1'b0, req0_rs = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req1_valid = 1'b0, req1_rs = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req0_ack, req1_ack, lcd_rs, lcd_e, init_done, busy;
  logic [7:0] lcd_db;

  lcd_bus_scheduler #(
    .SETUP_CYC(S), .E_HIGH_CYC(EH), .HOLD_CYC(H),
    .CMD_WAIT_CYC(CMD), .CLEAR_WAIT_CYC(CLR), .POWERUP_WAIT_CYC(P)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ack(req0_ack),
    .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ack(req1_ack),
    .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_db(lcd_db), .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  // Reference model state.
  logic [7:0] init_seq [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  bit         pend [2];
  int         set_c [2];
  logic       pay_rs [2];
  logic [7:0] pay_dat [2];
  int         idle_at = 0;
  bit         rr_ptr = 1'b0;
  int         n_exp [2];

  function automatic int wait_len(input logic rs, input logic [7:0] d);
    return (rs == 1'b0 && d >= 8'd1 && d <= 8'd3) ? CLR : CMD;
  endfunction

  // Protocol monitor: ack width, acks before init, simultaneous acks, ack counts.
  int n_ack0 = 0, n_ack1 = 0, n_wide = 0, n_early = 0, n_dual = 0;
  logic ack0_prev = 1'b0, ack1_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      ack0_prev <= 1'b0;
      ack1_prev <= 1'b0;
    end else begin
      if ((req0_ack && ack0_prev) || (req1_ack && ack1_prev)) n_wide <= n_wide + 1;
      if ((req0_ack || req1_ack) && !init_done) n_early <= n_early + 1;
      if (req0_ack && req1_ack) n_dual <= n_dual + 1;
      if (req0_ack) n_ack0 <= n_ack0 + 1;
      if (req1_ack) n_ack1 <= n_ack1 + 1;
      ack0_prev <= req0_ack;
      ack1_prev <= req1_ack;
    end
  end

  task automatic set_req(input int p, input logic rs, input logic [7:0] d);
    pay_rs[p] = rs; pay_dat[p] = d; pend[p] = 1'b1; set_c[p] = cyc;
    if (p == 0) begin req0_valid = 1'b1; req0_rs = rs; req0_data = d; end
    else        begin req1_valid = 1'b1; req1_rs = rs; req1_data = d; end
  endtask

  task automatic drop_req(input int p);
    pend[p] = 1'b0;
    if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic rand_req(input int p);
    logic rs;
    logic [7:0] d;
    rs = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
    d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
    set_req(p, rs, d);
  endtask

  // Follows one E pulse whose bus load edge is ld; RS/DB must sit at the expected value from ld through the first HOLD cycle.
  task automatic observe(input int ld, input logic [7:0] edb, input logic ers, input string tag);
    int bad, n, rise, fall;
    logic [7:0] db_rise;
    logic rs_rise;
    bad = 0; n = 0;
    while (lcd_e !== 1'b1 && n < BUDGET) begin
      if (cyc >= ld && (lcd_db !== edb || lcd_rs !== ers)) bad++;
      @(negedge clk); n++;
    end
    rise = cyc; db_rise = lcd_db; rs_rise = lcd_rs;
    while (lcd_e === 1'b1 && n < BUDGET) begin
      if (lcd_db !== edb || lcd_rs !== ers) bad++;
      @(negedge clk); n++;
    end
    fall = cyc;
    if (lcd_db !== edb || lcd_rs !== ers) bad++;
    check({tag, "_timeout"}, (n >= BUDGET) ? 1 : 0, 0);
    check({tag, "_e_rise"}, rise, ld + S);
    check({tag, "_e_fall"}, fall, ld + S + EH);
    check({tag, "_db"}, db_rise, edb);
    check({tag, "_rs"}, rs_rise, ers);
    check({tag, "_bus_stable"}, bad, 0);
  endtask

  task automatic run_init();
    int ld, idle;
    ld = cyc + P + 1;
    idle = 0;
    for (int i = 0; i < 4; i++) begin
      observe(ld, init_seq[i], 1'b0, "init");
      idle = ld + S + EH + H + wait_len(1'b0, init_seq[i]);
      ld = idle + 1;
    end
    while (cyc < idle - 1) @(negedge clk);
    check("init_done_before_end", init_done, 0);
    @(negedge clk);
    check("init_done_set", init_done, 1);
    check("busy_idle", busy, 0);
    idle_at = idle;
  endtask

  // Serves the next grant predicted by the model; reload re-raises the granted port with a fresh payload.
  task automatic serve_one(input bit reload, output int port);
    int first, e, exp_p, a, n;
    bit c0, c1;
    logic [7:0] edb;
    logic ers;
    first = 32'h7fffffff;
    for (int p = 0; p < 2; p++) if (pend[p] && set_c[p] < first) first = set_c[p];
    e = (idle_at > first) ? idle_at : first;
    c0 = pend[0] && set_c[0] <= e;
    c1 = pend[1] && set_c[1] <= e;
`ifdef LCD_SCHED_RR_EN
    exp_p = (c0 && c1) ? int'(rr_ptr) : (c0 ? 0 : 1);
    rr_ptr = (exp_p == 0);
`else
    exp_p = c0 ? 0 : 1;
`endif
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(req0_ack === 1'b1 || req1_ack === 1'b1) && n < BUDGET);
    port = (req1_ack === 1'b1) ? 1 : 0;
    check("ack_timeout", (n >= BUDGET) ? 1 : 0, 0);
    a = cyc;
    edb = pay_dat[exp_p];
    ers = pay_rs[exp_p];
    check("ack_port", port, exp_p);
    check("ack_cycle", a, e + 1);
    check("ack_db", lcd_db, edb);
    check("ack_rs", lcd_rs, ers);
    n_exp[exp_p]++;
    if (reload) rand_req(exp_p);
    else drop_req(exp_p);
    observe(a, edb, ers, "xfer");
    idle_at = a + S + EH + H + wait_len(ers, edb);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: run exceeded time limit after %0d checks", n_chk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int p, n, target, mode;
    logic [3:0] grants;
    rst_n = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    n_exp[0] = 0; n_exp[1] = 0;
    set_req(0, 1'b1, 8'h61);
    repeat (3) @(negedge clk);
    check("rst_lcd_e", lcd_e, 0);
    check("rst_lcd_db", lcd_db, 0);
    check("rst_lcd_rs", lcd_rs, 0);
    check("rst_ack0", req0_ack, 0);
    check("rst_ack1", req1_ack, 0);
    check("rst_init_done", init_done, 0);
    check("rst_busy", busy, 1);
    rst_n = 1'b1;
    run_init();

    // Request held since reset is served on the first IDLE cycle.
    serve_one(1'b0, p);

    // Clear command followed by a request queued during its long wait.
    set_req(1, 1'b0, 8'h01);
    serve_one(1'b0, p);
    repeat (30) @(negedge clk);
    set_req(0, 1'b1, 8'($urandom));
    serve_one(1'b0, p);
    set_req(1, 1'b1, 8'($urandom));
    serve_one(1'b0, p);

    // Both ports held for four transfers.
    rand_req(0);
    rand_req(1);
    grants = '0;
    for (int k = 0; k < 4; k++) begin
      serve_one(1'b1, p);
      grants[k] = p[0];
    end
    check("grant_sequence", grants, EXP_GRANTS);
    while (pend[0] || pend[1]) serve_one(1'b0, p);

    for (int it = 0; it < 12; it++) begin
      target = idle_at + int'($urandom_range(0, 13)) - 10;
      while (cyc < target) @(negedge clk);
      mode = int'($urandom_range(0, 2));
      if (mode != 1) rand_req(0);
      if (mode != 0) rand_req(1);
      while (pend[0] || pend[1]) serve_one(1'b0, p);
    end

    // Reset while E is high: outputs clear asynchronously and init replays.
    set_req(0, 1'b1, 8'h5A);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (req0_ack !== 1'b1 && n < BUDGET);
    check("mid_ack_timeout", (n >= BUDGET) ? 1 : 0, 0);
    n_exp[0]++;
    drop_req(0);
    n = 0;
    while (lcd_e !== 1'b1 && n < BUDGET) begin
      @(negedge clk); n++;
    end
    check("mid_e_timeout", (n >= BUDGET) ? 1 : 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_lcd_e", lcd_e, 0);
    check("async_lcd_db", lcd_db, 0);
    check("async_lcd_rs", lcd_rs, 0);
    check("async_init_done", init_done, 0);
    check("async_busy", busy, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_init();
    repeat (30) @(negedge clk);

    check("ack0_count", n_ack0, n_exp[0]);
    check("ack1_count", n_ack1, n_exp[1]);
    check("ack_width", n_wide, 0);
    check("ack_before_init", n_early, 0);
    check("ack_dual", n_dual, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
